// File: rtl/reg_wb_arbiter_pkg.sv
// Shared CPU definitions: data width, register-file geometry and writeback grant encoding.
package reg_wb_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_COUNT  = 32;

  typedef enum logic {
    GRANT_ALU  = 1'b0,
    GRANT_LONG = 1'b1
  } grant_e;

endpackage

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for long-latency destinations, plus the decode hazard (RAW/WAW) stall.
module reg_scoreboard
  import reg_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issueValid,
  input  logic                  issueLong,
  input  logic [REG_ADDR_W-1:0] issueRd,
  input  logic [REG_ADDR_W-1:0] issueRs1,
  input  logic [REG_ADDR_W-1:0] issueRs2,
  input  logic                  clearValid,
  input  logic [REG_ADDR_W-1:0] clearRd,
  output logic                  stall,
  output logic [REG_COUNT-1:0]  pendingMask
);

  logic [REG_COUNT-1:0] setVec;
  logic [REG_COUNT-1:0] clrVec;

  assign stall = issueValid &&
                 (pendingMask[issueRs1] || pendingMask[issueRs2] || pendingMask[issueRd]);

  always_comb begin
    setVec = '0;
    clrVec = '0;
    if (issueValid && issueLong && !stall && (issueRd != '0)) setVec[issueRd] = 1'b1;
    if (clearValid) clrVec[clearRd] = 1'b1;
  end

  // Register 0 is hardwired, so its pending bit is forced low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pendingMask <= '0;
    else     pendingMask <= ((pendingMask & ~clrVec) | setVec) & ~REG_COUNT'(1);
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin writeback arbiter between the ALU and the long-latency unit, with a registered
// register-file write port and a pending-destination scoreboard.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::REG_ADDR_W, reg_wb_arbiter_pkg::REG_COUNT;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] issueRd,
  input  logic [REG_ADDR_W-1:0] issueRs1,
  input  logic [REG_ADDR_W-1:0] issueRs2,
  input  logic                  issueLong,
  output logic                  stall,
  input  logic                  aluValid,
  input  logic [REG_ADDR_W-1:0] aluRd,
  input  logic [XLEN-1:0]       aluData,
  output logic                  aluReady,
  input  logic                  longValid,
  input  logic [REG_ADDR_W-1:0] longRd,
  input  logic [XLEN-1:0]       longData,
  output logic                  longReady,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       writeData,
  output logic [REG_COUNT-1:0]  pendingMask
);

  import reg_wb_arbiter_pkg::grant_e;
  import reg_wb_arbiter_pkg::GRANT_ALU;
  import reg_wb_arbiter_pkg::GRANT_LONG;

  grant_e rrLast;
  logic   contended;

  // rrLast holds the winner of the last contended cycle; the other requester wins next.
  assign contended = aluValid && longValid;
  assign aluReady  = !rst && aluValid  && (!longValid || (rrLast == GRANT_LONG));
  assign longReady = !rst && longValid && (!aluValid  || (rrLast == GRANT_ALU));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrLast    <= GRANT_LONG;
      regWrite  <= 1'b0;
      rd        <= '0;
      writeData <= '0;
    end else begin
      if (contended) rrLast <= aluReady ? GRANT_ALU : GRANT_LONG;
      if (aluReady) begin
        regWrite  <= (aluRd != '0);
        rd        <= aluRd;
        writeData <= aluData;
      end else if (longReady) begin
        regWrite  <= (longRd != '0);
        rd        <= longRd;
        writeData <= longData;
      end else begin
        regWrite  <= 1'b0;
      end
    end
  end

  reg_scoreboard uScoreboard (
    .clk        (clk),
    .rst        (rst),
    .issueValid (issueValid),
    .issueLong  (issueLong),
    .issueRd    (issueRd),
    .issueRs1   (issueRs1),
    .issueRs2   (issueRs2),
    .clearValid (longReady),
    .clearRd    (longRd),
    .stall      (stall),
    .pendingMask(pendingMask)
  );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized scoreboard bench for reg_wb_arbiter, followed by a directed asynchronous-reset scenario.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        issueValid, issueLong;
  logic [4:0]  issueRd, issueRs1, issueRs2;
  logic        stall;
  logic        aluValid, longValid, aluReady, longReady;
  logic [4:0]  aluRd, longRd, rd;
  logic [31:0] aluData, longData, writeData, pendingMask;
  logic        regWrite;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .issueValid(issueValid), .issueRd(issueRd), .issueRs1(issueRs1), .issueRs2(issueRs2),
    .issueLong(issueLong), .stall(stall),
    .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData), .aluReady(aluReady),
    .longValid(longValid), .longRd(longRd), .longData(longData), .longReady(longReady),
    .regWrite(regWrite), .rd(rd), .writeData(writeData), .pendingMask(pendingMask)
  );

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cyc     = 0;
  bit          chk     = 1'b0;

  // Reference model state: set of pending registers and whose turn it is on contention.
  logic [31:0] pend;
  bit          aluTurn;
  bit          aluGo, longGo, stallExp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: evaluates this cycle's expected handshakes and queues expected writes.
  always @(negedge clk) begin
    if (chk) begin : model
      bit expA, expL, expS;
      check("pendingMask", pendingMask, pend);
      expS = issueValid && (pend[issueRs1] || pend[issueRs2] || pend[issueRd]);
      check("stall", stall, expS);
      if (aluValid && longValid) begin
        expA    = aluTurn;
        expL    = !aluTurn;
        aluTurn = !aluTurn;
      end else begin
        expA = aluValid;
        expL = longValid;
      end
      check("grant", {aluReady, longReady}, {expA, expL});
      if (expA && aluRd != 0) expQ.push_back('{cyc + 1, aluRd, aluData});
      if (expL) begin
        if (longRd != 0) expQ.push_back('{cyc + 1, longRd, longData});
        pend[longRd] = 1'b0;
      end
      if (issueValid && issueLong && !expS && issueRd != 0) pend[issueRd] = 1'b1;
      aluGo    = expA;
      longGo   = expL;
      stallExp = expS;
    end
  end

  // Monitor: every register-file write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (chk) begin : monitor
      wr_t e;
      if (regWrite) begin
        if (expQ.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL spuriousWrite: got rd=%0d data=0x%0h expected no write (cycle %0d)",
                   rd, writeData, cyc);
        end else begin
          e = expQ.pop_front();
          check("writeCycle", 64'(cyc), 64'(e.cyc));
          check("writeRd", 64'(rd), 64'(e.rd));
          check("writeData", 64'(writeData), 64'(e.data));
        end
      end else if (expQ.size() != 0 && expQ[0].cyc <= cyc) begin
        e = expQ.pop_front();
        vectors++;
        errors++;
        $display("FAIL missingWrite: got regWrite=0 expected rd=%0d data=0x%0h (cycle %0d)",
                 e.rd, e.data, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    issueValid = 0; issueLong = 0; issueRd = 0; issueRs1 = 0; issueRs2 = 0;
    aluValid = 0; aluRd = 0; aluData = 0;
    longValid = 0; longRd = 0; longData = 0;
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    aluValid  = 1'b1;
    longValid = 1'b1;
    #2;
    check("resetRegWrite", 64'(regWrite), 64'd0);
    check("resetRdData", {27'd0, rd, writeData}, 64'd0);
    check("resetMask", 64'(pendingMask), 64'd0);
    check("resetReady", {aluReady, longReady}, 2'b00);
    step();
    idleInputs();
    pend    = '0;
    aluTurn = 1'b1;
    aluGo = 0; longGo = 0; stallExp = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if (!aluValid || aluGo) begin
        aluValid = ($urandom_range(0, 99) < 60);
        aluRd    = 5'($urandom_range(0, 7));
        aluData  = $urandom;
      end
      if (!longValid || longGo) begin
        longValid = ($urandom_range(0, 99) < 45);
        longRd    = 5'($urandom_range(0, 7));
        longData  = $urandom;
      end
      if (!(issueValid && stallExp)) begin
        issueValid = ($urandom_range(0, 99) < 70);
        issueLong  = ($urandom_range(0, 99) < 50);
        issueRd    = 5'($urandom_range(0, 7));
        issueRs1   = 5'($urandom_range(0, 7));
        issueRs2   = 5'($urandom_range(0, 7));
        if (longValid && issueLong && issueRd == longRd) issueLong = 1'b0;
      end
      step();
    end

    // Drain: let every outstanding write appear, then leave the model behind.
    idleInputs();
    repeat (4) step();
    chk = 1'b0;
    check("queueEmpty", 64'(expQ.size()), 64'd0);

    // Directed: asynchronous reset while a write and two pending bits are live.
    rst = 1'b1; #2; rst = 1'b0;
    issueValid = 1; issueLong = 1; issueRd = 3;
    step();
    issueRd = 7;
    step();
    issueValid = 0; issueLong = 0;
    aluValid = 1; aluRd = 9; aluData = 32'hDEAD_BEEF;
    step();
    check("preRstRegWrite", 64'(regWrite), 64'd1);
    check("preRstMask", 64'(pendingMask), 64'h88);
    #2 rst = 1'b1;
    #1;
    check("asyncRstRegWrite", 64'(regWrite), 64'd0);
    check("asyncRstRdData", {27'd0, rd, writeData}, 64'd0);
    check("asyncRstMask", 64'(pendingMask), 64'd0);
    check("asyncRstReady", {aluReady, longReady}, 2'b00);
    #1 rst = 1'b0;
    aluRd = 5; aluData = 32'h1234;
    longValid = 1; longRd = 2; longData = 32'hB;
    #1;
    check("postRstFirstGrant", {aluReady, longReady}, 2'b10);
    step();
    aluValid = 0;
    check("postRstWrite", {31'd0, regWrite, 27'd0, rd}, {31'd0, 1'b1, 27'd0, 5'd5});
    check("postRstWriteData", 64'(writeData), 64'h1234);
    check("longAfterAlu", {aluReady, longReady}, 2'b01);
    step();
    check("longWriteRd", {27'd0, rd, writeData}, {27'd0, 5'd2, 32'hB});
    longValid = 0;
    step();
    check("idleRegWrite", 64'(regWrite), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
